// File: rtl/core_muldiv_unit.sv
// core_muldiv_unit: RISC-V M-extension multiply/divide unit.
// Iterative radix-2 shift-add multiply and restoring divide, both one bit
// per cycle on a shared 2*XLEN accumulator. Divide-by-zero and signed
// overflow skip the iteration and finish one cycle after acceptance.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational product instead of the iterative path.
module core_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_muldiv_clk,
  input  logic            i_muldiv_rst,
  input  logic            i_muldiv_valid,
  input  logic [2:0]      i_muldiv_op,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic            i_muldiv_kill,
  output logic            o_muldiv_ready,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_done,
  output logic [XLEN-1:0] o_muldiv_result
);

  localparam int unsigned       CW       = $clog2(XLEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;

  // Latched request context
  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  // pend_q carries the finished value through DONE; result_q is only
  // committed when DONE completes, so a kill in DONE leaves it untouched.
  logic [XLEN-1:0]   pend_q;
  logic [XLEN-1:0]   result_q;

  // Request decode
  logic              accept;
  logic              req_div;
  logic              req_rem;
  logic              signed_a;
  logic              signed_b;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              div_ovf;
  logic              bypass;
  logic [XLEN-1:0]   bypass_val;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Iteration and fix-up datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   fix_val;

  assign accept = (state_q == S_IDLE) && i_muldiv_valid && !i_muldiv_kill;

  // Decode operand signedness, magnitudes and the early-completion cases
  always_comb begin
    req_div  = i_muldiv_op[2];
    req_rem  = i_muldiv_op[2] & i_muldiv_op[1];
    signed_a = (i_muldiv_op == 3'd1) || (i_muldiv_op == 3'd2) ||
               (i_muldiv_op == 3'd4) || (i_muldiv_op == 3'd6);
    signed_b = (i_muldiv_op == 3'd1) || (i_muldiv_op == 3'd4) ||
               (i_muldiv_op == 3'd6);
    sign_a   = signed_a & i_muldiv_rs1[XLEN-1];
    sign_b   = signed_b & i_muldiv_rs2[XLEN-1];
    abs_a    = sign_a ? -i_muldiv_rs1 : i_muldiv_rs1;
    abs_b    = sign_b ? -i_muldiv_rs2 : i_muldiv_rs2;
    div_zero = req_div & (i_muldiv_rs2 == '0);
    div_ovf  = req_div & ~i_muldiv_op[0] &
               (i_muldiv_rs1 == MOST_NEG) & (i_muldiv_rs2 == '1);
    bypass     = div_zero | div_ovf;
    bypass_val = '0;
    if (div_zero) begin
      bypass_val = req_rem ? i_muldiv_rs1 : '1;
    end else if (div_ovf) begin
      bypass_val = req_rem ? '0 : MOST_NEG;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{sign_a}}, i_muldiv_rs1} * {{XLEN{sign_b}}, i_muldiv_rs2};
    if (!req_div) begin
      bypass     = 1'b1;
      bypass_val = (i_muldiv_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One multiply or divide step on the shared accumulator.
  // Multiply: acc = {partial_hi, multiplier}; add on LSB, shift right.
  // Divide:   acc = {remainder, dividend}; shift left, subtract if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    acc_step  = op_q[2] ? div_next : mul_next;
  end

  // Apply the result sign and pick the requested half / quotient / remainder
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (op_q[2]) begin
      fix_val = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_val = prod_fix[XLEN-1:0];
    end else begin
      fix_val = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge i_muldiv_clk) begin
    if (i_muldiv_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = bypass ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (i_muldiv_kill) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = i_muldiv_kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers: latch on accept, iterate in CALC, fix up, commit
  always_ff @(posedge i_muldiv_clk) begin
    if (i_muldiv_rst) begin
      op_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      pend_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= i_muldiv_op;
            b_q   <= abs_b;
            neg_q <= req_rem ? sign_a : (sign_a ^ sign_b);
            cnt_q <= '0;
            acc_q <= {{XLEN{1'b0}}, abs_a};
            if (bypass) begin
              pend_q <= bypass_val;
            end
          end
        end
        S_CALC: begin
          if (i_muldiv_kill || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (!i_muldiv_kill) begin
            acc_q <= acc_step;
          end
        end
        S_FIX: begin
          if (!i_muldiv_kill) begin
            pend_q <= fix_val;
          end
        end
        S_DONE: begin
          if (!i_muldiv_kill) begin
            result_q <= pend_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_muldiv_ready  = (state_q == S_IDLE);
  assign o_muldiv_busy   = (state_q != S_IDLE);
  assign o_muldiv_done   = (state_q == S_DONE) && !i_muldiv_kill;
  assign o_muldiv_result = o_muldiv_done ? pend_q : result_q;

endmodule

// File: tb/tb_core_muldiv_unit.sv
// Self-checking bench for core_muldiv_unit (XLEN=32).
// Expected results and completion latencies are queued when a request is
// driven and popped when the unit signals done.
module tb_core_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  logic [31:0] last_res;

  core_muldiv_unit #(.XLEN(XLEN)) dut (
    .i_muldiv_clk   (clk),
    .i_muldiv_rst   (rst),
    .i_muldiv_valid (valid),
    .i_muldiv_op    (op),
    .i_muldiv_rs1   (rs1),
    .i_muldiv_rs2   (rs2),
    .i_muldiv_kill  (kill),
    .o_muldiv_ready (ready),
    .o_muldiv_busy  (busy),
    .o_muldiv_done  (done),
    .o_muldiv_result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    int ia, ib;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Drive one request at the current negedge (unit must be idle), scramble
  // the inputs after acceptance, and wait (bounded) for done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    exp_res_q.push_back(model_res(f, a, b));
    exp_lat_q.push_back(exp_lat(f, a, b));
    op = f; rs1 = a; rs2 = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    op  = 3'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
    res = 'x;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done === 1'b1) begin
        lat = i;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; kill = 1'b0; op = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    last_res = 32'd0;
  endtask

  task automatic test_mul();
    logic [2:0]  t_op[7] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd3};
    logic [31:0] t_a[7]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                             32'hFFFFFFFE, 32'h12345678, 32'd0};
    logic [31:0] t_b[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'h80000000,
                             32'd3, 32'h9ABCDEF0, 32'hFFFFFFFF};
    logic [31:0] res, e_res;
    int lat, e_lat;
    for (int k = 0; k < 7; k++) begin
      run_op(t_op[k], t_a[k], t_b[k], res, lat);
      e_res = exp_res_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      checks++; if (res !== e_res) begin errors++; $display("FAIL mul%0d_result: got %h expected %h", k, res, e_res); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL mul%0d_latency: got %0d expected %0d", k, lat, e_lat); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mul%0d_ready_after: got %b expected 1", k, ready); end
      checks++; if (result !== e_res) begin errors++; $display("FAIL mul%0d_hold: got %h expected %h", k, result, e_res); end
      last_res = e_res;
    end
  endtask

  task automatic test_div();
    logic [2:0]  t_op[11] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd6, 3'd4, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5};
    logic [31:0] t_a[11]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'd0, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] t_b[11]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd1, 32'd1};
    logic [31:0] res, e_res;
    int lat, e_lat;
    for (int k = 0; k < 11; k++) begin
      run_op(t_op[k], t_a[k], t_b[k], res, lat);
      e_res = exp_res_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      checks++; if (res !== e_res) begin errors++; $display("FAIL div%0d_result: got %h expected %h", k, res, e_res); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL div%0d_latency: got %0d expected %0d", k, lat, e_lat); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL div%0d_ready_after: got %b expected 1", k, ready); end
      checks++; if (result !== e_res) begin errors++; $display("FAIL div%0d_hold: got %h expected %h", k, result, e_res); end
      last_res = e_res;
    end
  endtask

  task automatic test_random();
    logic [31:0] res, e_res, a, b;
    logic [2:0] f;
    int lat, e_lat;
    for (int k = 0; k < 16; k++) begin
      f = 3'(k % 8);
      a = $urandom;
      b = (k % 5 == 4) ? 32'd0 : $urandom;
      if (k % 3 == 0) b = {{28{b[31]}}, b[3:0]};
      run_op(f, a, b, res, lat);
      e_res = exp_res_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      checks++; if (res !== e_res) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h expected %h", k, f, a, b, res, e_res); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", k, lat, e_lat); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_after: got %b expected 1", k, ready); end
      last_res = e_res;
    end
  endtask

  task automatic test_kill();
    bit seen;
    // DIV 100/7 killed during cycle T+10
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    seen = 0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1) seen = 1;
      @(negedge clk);
    end
    kill = 1'b1;
    #1;
    if (done === 1'b1) seen = 1;
    @(negedge clk);
    kill = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kill_calc_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_calc_busy: got %b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL kill_calc_no_done: got 1 expected 0"); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL kill_calc_result: got %h expected %h", result, last_res); end

    // Kill coincident with valid in IDLE: no acceptance
    op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_idle_busy: got %b expected 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL kill_idle_no_done: got 1 expected 0"); end

    // Kill while in DONE (divide-by-zero bypass lands there at T+1)
    op = 3'd5; rs1 = 32'd77; rs2 = 32'd0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; kill = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL kill_done_pulse: got %b expected 0", done); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL kill_done_result: got %h expected %h", result, last_res); end
    @(negedge clk);
    kill = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kill_done_ready: got %b expected 1", ready); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL kill_done_hold: got %h expected %h", result, last_res); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    seen = 0;
    for (int i = 1; i < 5; i++) begin
      if (done === 1'b1) seen = 1;
      @(negedge clk);
    end
    rst = 1'b1; valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; kill = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", result); end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_done: got 1 expected 0"); end
    last_res = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t_op[4] = '{3'd0, 3'd0, 3'd6, 3'd1};
    logic [31:0] t_a[4]  = '{32'd7, 32'hFFFF0001, 32'hFFFFFF9C, 32'h7FFFFFFF};
    logic [31:0] t_b[4]  = '{32'hFFFFFFFD, 32'h00010001, 32'd7, 32'h7FFFFFFF};
    logic [31:0] res, e_res;
    int lat, e_lat;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b expected 1", k, ready); end
      run_op(t_op[k], t_a[k], t_b[k], res, lat);
      e_res = exp_res_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      checks++; if (res !== e_res) begin errors++; $display("FAIL b2b%0d_result: got %h expected %h", k, res, e_res); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", k, lat, e_lat); end
      @(negedge clk);
    end
    checks++; if (exp_res_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_res_q.size()); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    last_res = '0;
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
